aes_decipher_top: RTL and testbench

AES_DECIPHER_TOP -- requirements
Module: aes_decipher_top

---
 rtl/aes_dec_pkg.sv | 99 +++++++++
 rtl/aes_inv_sbox.sv | 15 +
 rtl/aes_sbox.sv | 15 +
 rtl/aes_decipher_top.sv | 149 ++++++++++++++
 tb/tb_aes_decipher_top.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/aes_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_dec_pkg
// Purpose  : Shared FSM encoding, round constants and GF(2^8) helpers for AES-128 decipher
// Revision : 1.0
// ============================================================================
package aes_dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_KEXP = 2'd1,
      ST_DEC  = 2'd2
   } state_t;

   localparam int NUM_ROUNDS = 10;

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse (and maps 0 to 0, as the S-box needs)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
      return gf_mul(r, r);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] v;
      v = gf_inv(x);
      return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
   endfunction

   // Byte (r,c) of the column-major state sits at index 4c+r, MSB first
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)&3)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gf_mul(a0,8'h0e)^gf_mul(a1,8'h0b)^gf_mul(a2,8'h0d)^gf_mul(a3,8'h09);
         o[119-32*c -: 8] = gf_mul(a0,8'h09)^gf_mul(a1,8'h0e)^gf_mul(a2,8'h0b)^gf_mul(a3,8'h0d);
         o[111-32*c -: 8] = gf_mul(a0,8'h0d)^gf_mul(a1,8'h09)^gf_mul(a2,8'h0e)^gf_mul(a3,8'h0b);
         o[103-32*c -: 8] = gf_mul(a0,8'h0b)^gf_mul(a1,8'h0d)^gf_mul(a2,8'h09)^gf_mul(a3,8'h0e);
      end
      return o;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_sbox
// Purpose  : AES inverse S-box, 8-bit combinational
// Revision : 1.0
// ============================================================================
module aes_inv_sbox
   import aes_dec_pkg::*;
(
   input  logic [7:0] x,
   output logic [7:0] y
);
   assign y = sbox_inv(x);
endmodule
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Purpose  : AES forward S-box, 8-bit combinational
// Revision : 1.0
// ============================================================================
module aes_sbox
   import aes_dec_pkg::*;
(
   input  logic [7:0] x,
   output logic [7:0] y
);
   assign y = sbox_fwd(x);
endmodule
`default_nettype wire

// File: rtl/aes_decipher_top.sv
`default_nettype none
// ============================================================================
// Module   : aes_decipher_top
// Purpose  : Iterative AES-128 decipher, one round per cycle, on-the-fly reverse key schedule
// Revision : 1.0
// ============================================================================
module aes_decipher_top
   import aes_dec_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         kld,
   input  logic [127:0] key,
   input  logic         ld,
   input  logic [127:0] text_in,
   output logic [127:0] text_out,
   output logic         done,
   output logic         key_rdy,
   output logic         busy
);
   state_t       state, state_nxt;
   logic [3:0]   rnd;
   logic         fin;
   logic [127:0] kreg, rk10, st;
   logic         key_start, kexp_step, kexp_last, dec_start, dec_round, dec_out;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      key_start = 1'b0;
      kexp_step = 1'b0;
      kexp_last = 1'b0;
      dec_start = 1'b0;
      dec_round = 1'b0;
      dec_out   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (kld) begin
               key_start = 1'b1;
               state_nxt = ST_KEXP;
            end else if (ld && key_rdy) begin
               dec_start = 1'b1;
               state_nxt = ST_DEC;
            end
         end
         ST_KEXP: begin
            if (kld) begin
               key_start = 1'b1;
            end else begin
               kexp_step = 1'b1;
               if (rnd == 4'(NUM_ROUNDS)) begin
                  kexp_last = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_DEC: begin
            // One extra cycle after round 0 moves the result into text_out
            if (fin) begin
               dec_out   = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               dec_round = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   // Shared SubWord: forward step in KEXP, reverse step in DEC
   logic [31:0]  w0, w1, w2, w3, rw3, sw_in, sw_rot, sw_out, rcw;
   logic [127:0] fwd_key, rk_cur;
   assign {w0, w1, w2, w3} = kreg;
   assign rw3    = w3 ^ w2;
   assign sw_in  = (state == ST_DEC) ? rw3 : w3;
   assign sw_rot = {sw_in[23:0], sw_in[31:24]};
   assign rcw    = {rcon((state == ST_DEC) ? rnd + 4'd1 : rnd), 24'h0};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (.x(sw_rot[8*i +: 8]), .y(sw_out[8*i +: 8]));
   end

   logic [31:0] f0, f1, f2, f3;
   assign f0 = w0 ^ sw_out ^ rcw;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;
   assign fwd_key = {f0, f1, f2, f3};
   assign rk_cur  = {w0 ^ sw_out ^ rcw, w1 ^ w0, w2 ^ w1, rw3};

   logic [127:0] isr, isb, ark, imc;
   assign isr = inv_shift_rows(st);

   for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
      aes_inv_sbox u_inv_sbox (.x(isr[8*i +: 8]), .y(isb[8*i +: 8]));
   end

   assign ark = isb ^ rk_cur;
   assign imc = inv_mix_columns(ark);

   always_ff @(posedge clk) begin
      if (rst) begin
         kreg     <= '0;
         rk10     <= '0;
         st       <= '0;
         rnd      <= '0;
         fin      <= 1'b0;
         text_out <= '0;
         done     <= 1'b0;
         key_rdy  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (key_start) begin
            kreg    <= key;
            rnd     <= 4'd1;
            key_rdy <= 1'b0;
         end else if (kexp_step) begin
            kreg <= fwd_key;
            rnd  <= rnd + 4'd1;
            if (kexp_last) begin
               rk10    <= fwd_key;
               key_rdy <= 1'b1;
               rnd     <= '0;
            end
         end else if (dec_start) begin
            st   <= text_in ^ rk10;
            kreg <= rk10;
            rnd  <= 4'd9;
            fin  <= 1'b0;
         end else if (dec_round) begin
            st   <= (rnd == 4'd0) ? ark : imc;
            kreg <= rk_cur;
            if (rnd == 4'd0) fin <= 1'b1;
            else             rnd <= rnd - 4'd1;
         end else if (dec_out) begin
            text_out <= st;
            done     <= 1'b1;
            fin      <= 1'b0;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_aes_decipher_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_decipher_top
// Purpose  : Directed-vector self-checking bench for aes_decipher_top
// Revision : 1.0
// ============================================================================
module tb_aes_decipher_top;
   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] PT2 = 128'h6bc1bee22e409f96e93d7e117393172a;

   logic         clk = 1'b0;
   logic         rst, kld, ld;
   logic [127:0] key, text_in, text_out;
   logic         done, key_rdy, busy;
   int           n_tests = 0;
   int           n_fail  = 0;
   int           done_cnt = 0;

   aes_decipher_top dut (
      .clk(clk), .rst(rst), .kld(kld), .key(key), .ld(ld), .text_in(text_in),
      .text_out(text_out), .done(done), .key_rdy(key_rdy), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic wait_key_rdy(output int lat);
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (key_rdy) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic load_key(input logic [127:0] k, output int lat);
      key = k; kld = 1'b1;
      tick();
      kld = 1'b0;
      wait_key_rdy(lat);
   endtask

   task automatic run_block(input logic [127:0] ct, output int lat);
      text_in = ct; ld = 1'b1;
      tick();
      ld = 1'b0;
      wait_done(lat);
   endtask

   initial begin
      int lat;
      int d0;
      rst = 1'b1; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_text_out", text_out, 128'd0);
      check("rst_done",     128'(done),    128'd0);
      check("rst_key_rdy",  128'(key_rdy), 128'd0);
      check("rst_busy",     128'(busy),    128'd0);

      // ld without a key must be ignored
      text_in = CT1; ld = 1'b1;
      tick(); tick(); tick();
      ld = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("nokey_done_cnt", 128'(done_cnt), 128'd0);
      check("nokey_text_out", text_out, 128'd0);
      check("nokey_busy",     128'(busy), 128'd0);

      // FIPS-197 C.1 vector
      load_key(K1, lat);
      check("k1_kexp_lat", 128'(lat), 128'd10);
      check("k1_busy_idle", 128'(busy), 128'd0);
      run_block(CT1, lat);
      check("c1_lat", 128'(lat), 128'd11);
      check("c1_pt",  text_out, PT1);
      tick();
      check("c1_done_width", 128'(done), 128'd0);
      check("c1_key_rdy",    128'(key_rdy), 128'd1);
      check("c1_busy",       128'(busy), 128'd0);

      // ld while busy is dropped, not queued
      d0 = done_cnt;
      text_in = CT1; ld = 1'b1;
      tick();
      ld = 1'b0;
      tick(); tick(); tick();
      text_in = CT2; ld = 1'b1;
      tick();
      ld = 1'b0;
      wait_done(lat);
      check("busy_ld_pt", text_out, PT1);
      for (int i = 0; i < 15; i++) tick();
      check("busy_ld_done_cnt", 128'(done_cnt), 128'(d0 + 1));
      check("busy_ld_hold", text_out, PT1);

      // SP 800-38A ECB vector, then back-to-back block
      load_key(K2, lat);
      check("k2_kexp_lat", 128'(lat), 128'd10);
      check("k2_hold_during_kexp", text_out, PT1);
      run_block(CT2, lat);
      check("ecb_lat", 128'(lat), 128'd11);
      check("ecb_pt",  text_out, PT2);
      tick();
      run_block(CT2, lat);
      check("b2b_lat", 128'(lat), 128'd11);
      check("b2b_pt",  text_out, PT2);
      tick();

      // kld wins over ld in the same IDLE cycle
      d0 = done_cnt;
      key = K1; kld = 1'b1; text_in = CT1; ld = 1'b1;
      tick();
      kld = 1'b0; ld = 1'b0;
      check("kld_ld_busy",    128'(busy), 128'd1);
      check("kld_ld_key_rdy", 128'(key_rdy), 128'd0);
      wait_key_rdy(lat);
      check("kld_ld_kexp_lat", 128'(lat), 128'd10);
      check("kld_ld_no_done",  128'(done_cnt), 128'(d0));
      check("kld_ld_hold",     text_out, PT2);
      run_block(CT1, lat);
      check("kld_ld_newkey_pt", text_out, PT1);
      tick();

      // kld during DEC is ignored; old key stays
      text_in = CT1; ld = 1'b1;
      tick();
      ld = 1'b0;
      tick(); tick(); tick();
      key = K2; kld = 1'b1;
      tick();
      kld = 1'b0;
      wait_done(lat);
      check("kld_dec_pt", text_out, PT1);
      tick();
      check("kld_dec_busy",    128'(busy), 128'd0);
      check("kld_dec_key_rdy", 128'(key_rdy), 128'd1);
      run_block(CT1, lat);
      check("kld_dec_oldkey_pt", text_out, PT1);
      tick();

      // reset while round 5 is pending
      d0 = done_cnt;
      text_in = CT1; ld = 1'b1;
      tick();
      ld = 1'b0;
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_text_out", text_out, 128'd0);
      check("mid_rst_done",     128'(done), 128'd0);
      check("mid_rst_key_rdy",  128'(key_rdy), 128'd0);
      check("mid_rst_busy",     128'(busy), 128'd0);
      for (int i = 0; i < 20; i++) tick();
      check("mid_rst_no_done", 128'(done_cnt), 128'(d0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
